ula_seq: RTL

Parameterised, registered successor of the 8-bit combinational ALU (ula_bits).
- Adds a valid/ready handshake on both sides, status flags, shift operations and a multi-cycle unsigned shift-add multiplier.
- Single-entry: holds at most one operation in flight.
- Sits between the operand register file and the result write-back stage of the teaching datapath.

---
 rtl/ula_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// ula_seq: registered ALU with valid/ready on both sides, status flags,
// shifts and an iterative unsigned shift-add multiplier. At most one
// operation is in flight at a time.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid / in_ready     operation handshake (A, B, carry_in, seletor)
//   out_valid / out_ready   result handshake
//   resultado               result (low word for MUL)
//   resultado_alto          MUL high word, 0 otherwise
//   carry_out, zero, negativo, overflow, erro   status flags
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  input  logic [3:0]       seletor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_alto,
  output logic             carry_out,
  output logic             zero,
  output logic             negativo,
  output logic             overflow,
  output logic             erro
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [3:0] SEL_MUL = 4'b1001;

  typedef enum logic [1:0] {OCIOSO, CALC, SAIDA} estado_t;

  estado_t            state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
  logic               cout_q, cout_d, zero_q, zero_d, neg_q, neg_d;
  logic               ovf_q, ovf_d, err_q, err_d;

  // Single-cycle datapath, evaluated on the live inputs so the result is
  // registered at the accept edge.
  logic [WIDTH:0]   soma, dif;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_e;

  always_comb begin
    soma    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, carry_in};
    dif     = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, carry_in};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (seletor)
      4'b0000: alu_res = A & B;
      4'b0001: alu_res = A | B;
      4'b0010: alu_res = ~A;
      4'b0011: alu_res = ~(A & B);
      4'b0100: begin
        alu_res = soma[WIDTH-1:0];
        alu_c   = soma[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (soma[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0101: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];  // wraps negative => borrow
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      4'b0110: alu_res = A ^ B;
      4'b0111: begin
        alu_res = {A[WIDTH-2:0], 1'b0};
        alu_c   = A[WIDTH-1];
      end
      4'b1000: begin
        alu_res = {1'b0, A[WIDTH-1:1]};
        alu_c   = A[0];
      end
      default: alu_e = 1'b1;  // 1001 never reaches here; 1010..1111 invalid
    endcase
  end

  // One shift-add step: acc = {partial high, remaining multiplier bits}.
  // Adding A into the high half then shifting right consumes one
  // multiplier bit per clock.
  logic [WIDTH:0]     parc;
  logic [2*WIDTH-1:0] acc_nx;

  always_comb begin
    parc   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_nx = {parc, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    acc_d     = acc_q;
    res_d     = res_q;
    hi_d      = hi_q;
    cout_d    = cout_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      OCIOSO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (seletor == SEL_MUL) begin
            a_d     = A;
            acc_d   = {{WIDTH{1'b0}}, B};
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            res_d   = alu_res;
            hi_d    = '0;
            cout_d  = alu_c;
            zero_d  = (alu_res == '0);
            neg_d   = alu_res[WIDTH-1];
            ovf_d   = alu_v;
            err_d   = alu_e;
            state_d = SAIDA;
          end
        end
      end
      CALC: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + CW'(1);
        // Final iteration writes the product straight into the outputs.
        if (cnt_q == CW'(WIDTH-1)) begin
          res_d   = acc_nx[WIDTH-1:0];
          hi_d    = acc_nx[2*WIDTH-1:WIDTH];
          cout_d  = |acc_nx[2*WIDTH-1:WIDTH];
          zero_d  = (acc_nx == '0);
          neg_d   = acc_nx[WIDTH-1];
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = SAIDA;
        end
      end
      SAIDA: begin
        out_valid = 1'b1;
        if (out_ready) state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCIOSO;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign resultado      = res_q;
  assign resultado_alto = hi_q;
  assign carry_out      = cout_q;
  assign zero           = zero_q;
  assign negativo       = neg_q;
  assign overflow       = ovf_q;
  assign erro           = err_q;

endmodule
